// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bits.
// Every bit lasts the prescale value captured when the byte is accepted.
module uart_tx_serializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int STOP_BITS      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy
);

    localparam int                IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    state_reg,    state_next;
    logic [DATA_WIDTH-1:0]     shift_reg,    shift_next;
    logic [IDX_W-1:0]          idx_reg,      idx_next;
    logic [PRESCALE_WIDTH-1:0] cnt_reg,      cnt_next;
    logic [PRESCALE_WIDTH-1:0] period_reg,   period_next;
    logic                      par_en_reg,   par_en_next;
    logic                      par_bit_reg,  par_bit_next;
    logic                      stop_idx_reg, stop_idx_next;
    logic                      tx_out_reg,   tx_out_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            shift_reg    <= '0;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            period_reg   <= '0;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            stop_idx_reg <= 1'b0;
            tx_out_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            period_reg   <= period_next;
            par_en_reg   <= par_en_next;
            par_bit_reg  <= par_bit_next;
            stop_idx_reg <= stop_idx_next;
            tx_out_reg   <= tx_out_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        period_next   = period_reg;
        par_en_next   = par_en_reg;
        par_bit_next  = par_bit_reg;
        stop_idx_next = stop_idx_reg;
        tx_out_next   = tx_out_reg;

        if (state_reg == S_IDLE) begin
            tx_out_next = 1'b1;
            if (tx_valid) begin
                state_next    = S_START;
                shift_next    = tx_data;
                period_next   = prescale;
                // prescale of 0 wraps to all-ones, giving 2^PRESCALE_WIDTH cycles
                cnt_next      = prescale - PRESCALE_WIDTH'(1);
                par_en_next   = par_en;
                par_bit_next  = (^tx_data) ^ par_typ;
                idx_next      = '0;
                stop_idx_next = 1'b0;
                tx_out_next   = 1'b0;
            end
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - PRESCALE_WIDTH'(1);
        end else begin
            cnt_next = period_reg - PRESCALE_WIDTH'(1);
            case (state_reg)
                S_START: begin
                    state_next  = S_DATA;
                    tx_out_next = shift_reg[0];
                    shift_next  = shift_reg >> 1;
                end
                S_DATA: begin
                    if (idx_reg == LAST_IDX) begin
                        if (par_en_reg) begin
                            state_next  = S_PARITY;
                            tx_out_next = par_bit_reg;
                        end else begin
                            state_next  = S_STOP;
                            tx_out_next = 1'b1;
                        end
                    end else begin
                        idx_next    = idx_reg + IDX_W'(1);
                        tx_out_next = shift_reg[0];
                        shift_next  = shift_reg >> 1;
                    end
                end
                S_PARITY: begin
                    state_next  = S_STOP;
                    tx_out_next = 1'b1;
                end
                S_STOP: begin
                    tx_out_next = 1'b1;
                    if (stop_idx_reg == STOP_LAST) begin
                        state_next = S_IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
                default: begin
                    state_next  = S_IDLE;
                    tx_out_next = 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = (state_reg == S_IDLE);
    assign busy     = (state_reg != S_IDLE);
    assign tx_out   = tx_out_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: table vectors, corner sequences and random frames
// checked against a bit-sequence model of the UART frame.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       tx_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_tx_serializer #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6),
        .STOP_BITS     (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .par_en  (par_en),
        .par_typ (par_typ),
        .prescale(prescale),
        .tx_out  (tx_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [5:0] pres;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // mode 0: plain frame, 1: keep tx_valid high (back-to-back), 2: disturb inputs mid-frame
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] pr, input int mode,
                             output int busy_len, output logic par_sample);
        int   p;
        int   n;
        int   first_bad;
        logic exp_bits[$];
        logic act_bits[$];
        p = (pr == 6'd0) ? 64 : int'(pr);
        for (int c = 0; c < p; c++) exp_bits.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < p; c++) exp_bits.push_back(d[b]);
        if (pe)
            for (int c = 0; c < p; c++) exp_bits.push_back((^d) ^ pt);
        for (int c = 0; c < p; c++) exp_bits.push_back(1'b1);

        tx_data  = d;
        par_en   = pe;
        par_typ  = pt;
        prescale = pr;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_before_accept"}, tx_ready, 1'b1);
        @(posedge clk);
        #1;
        if (mode != 1) tx_valid = 1'b0;

        busy_len = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            @(negedge clk);
            act_bits.push_back(tx_out);
            if (busy === 1'b1) busy_len++;
            if (mode == 2) begin
                if (i == 2 * p) begin
                    tx_data  = 8'hFF;
                    prescale = 6'd16;
                    par_en   = 1'b1;
                end
                if (i == 3 * p) tx_valid = 1'b1;
                if (i == 6 * p) tx_valid = 1'b0;
            end
        end

        first_bad = -1;
        for (int i = 0; i < exp_bits.size(); i++)
            if (act_bits[i] !== exp_bits[i] && first_bad < 0) first_bad = i;
        checks++;
        if (first_bad >= 0) begin
            failures++;
            $display("FAIL %s_frame_bits cycle=%0d actual=%b expected=%b", tag, first_bad,
                     act_bits[first_bad], exp_bits[first_bad]);
        end
        check({tag, "_busy_len"}, busy_len, exp_bits.size());
        par_sample = pe ? act_bits[9 * p] : 1'bx;

        @(negedge clk);
        check({tag, "_end_idle{tx_out,busy,ready}"}, {tx_out, busy, tx_ready}, 3'b101);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        int         blen;
        logic       psamp;
        int         n;
        logic [7:0] rd;
        logic       rpe;
        logic       rpt;
        logic [5:0] rpr;

        vecs[0] = '{"basic_a5_p8",   8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 80};
        vecs[1] = '{"par_even_a5",   8'hA5, 1'b1, 1'b0, 6'd4, 1'b0, 44};
        vecs[2] = '{"par_odd_a5",    8'hA5, 1'b1, 1'b1, 6'd4, 1'b1, 44};
        vecs[3] = '{"par_even_07",   8'h07, 1'b1, 1'b0, 6'd4, 1'b1, 44};
        vecs[4] = '{"pres1_81",      8'h81, 1'b0, 1'b0, 6'd1, 1'b0, 10};
        vecs[5] = '{"pres0_00",      8'h00, 1'b0, 1'b0, 6'd0, 1'b0, 640};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        prescale = 6'd0;
        repeat (3) @(negedge clk);
        check("reset_state{tx_out,busy,ready}", {tx_out, busy, tx_ready}, 3'b101);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle{tx_out,busy,ready}", {tx_out, busy, tx_ready}, 3'b101);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].name, vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].pres, 0, blen, psamp);
            check({vecs[v].name, "_len"}, blen, vecs[v].exp_len);
            if (vecs[v].pe) check({vecs[v].name, "_parity"}, psamp, vecs[v].exp_par);
            $display("vector %s data=%02h pe=%0d pt=%0d pres=%0d busy_len=%0d", vecs[v].name,
                     vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].pres, blen);
        end

        // back-to-back: the second accept lands on the single idle cycle
        run_frame("b2b_first_55", 8'h55, 1'b0, 1'b0, 6'd2, 1, blen, psamp);
        run_frame("b2b_second_0f", 8'h0F, 1'b0, 1'b0, 6'd2, 0, blen, psamp);
        $display("back-to-back 55,0f pres=2 done");

        run_frame("midframe_change_3c", 8'h3C, 1'b0, 1'b0, 6'd8, 2, blen, psamp);
        $display("mid-frame input change 3c pres=8 busy_len=%0d", blen);

        // reset during data bit 3
        tx_data  = 8'hA5;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        prescale = 6'd8;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (35) @(negedge clk);
        check("midreset_in_bit3{tx_out,busy}", {tx_out, busy}, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_abort{tx_out,busy,ready}", {tx_out, busy, tx_ready}, 3'b101);
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_reset_c3", 8'hC3, 1'b1, 1'b1, 6'd3, 0, blen, psamp);
        $display("reset mid-frame then fresh frame c3 busy_len=%0d", blen);

        for (int r = 0; r < 24; r++) begin
            rd  = 8'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            rpr = 6'($urandom_range(1, 7));
            run_frame($sformatf("rand%0d", r), rd, rpe, rpt, rpr, ($urandom_range(0, 3) == 0) ? 1 : 0,
                      blen, psamp);
            $display("random %0d data=%02h pe=%0d pt=%0d pres=%0d busy_len=%0d", r, rd, rpe, rpt, rpr, blen);
        end
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit path: the serializing end matching the team's oversampled UART receiver. It accepts a parallel byte over a valid/ready handshake and drives one frame on tx_out. The frame is a start bit, DATA_WIDTH data bits LSB-first, an optional parity bit, and STOP_BITS stop bits. Each bit lasts prescale clk cycles, so the same prescale value programs both TX and RX for a matched baud rate.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESCALE_WIDTH, 6, width of the prescale input and bit-period counter
STOP_BITS, 1, number of stop bits; legal values are 1 or 2

Ports:
clk  input  1  single system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
tx_data  input  DATA_WIDTH  byte to send; captured on accept
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a byte; high only in IDLE
par_en  input  1  1 = insert parity bit; captured on accept
par_typ  input  1  0 = even parity, 1 = odd parity; captured on accept
prescale  input  PRESCALE_WIDTH  clk cycles per bit; captured on accept
tx_out  output  1  serial line, registered, idles high
busy  output  1  high from the cycle after accept through the last stop-bit cycle

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, tx_out=1, busy=0, tx_ready=1. The shift register, bit counter and cycle counter clear to 0.
- Reset mid-frame aborts the frame at that edge: the line returns high immediately and no partial bits follow.
- Accept: tx_valid && tx_ready at edge k captures tx_data, par_en, par_typ and prescale.
- Parity is computed at accept: the XOR of the captured data, inverted when par_typ=1.
- Input changes after accept have no effect on the frame in flight.
- FSM states: IDLE -> START -> DATA -> (PARITY if par_en) -> STOP -> IDLE.
- tx_out is a registered output:
  - It is 0 from edge k+1 (START).
  - Each state holds for exactly P clk cycles, where P = the captured prescale value.
  - A bit-period down-counter loads P-1 and advances state or bit on reaching 0.
- P=0 behaves as 2^PRESCALE_WIDTH (64 cycles for the default width), because the counter wraps. P=1 gives one cycle per bit.
- DATA: sends bit 0 first. A 3-bit index counts to DATA_WIDTH-1, then moves to PARITY or STOP.
- STOP: tx_out=1 for STOP_BITS*P cycles, then IDLE.
- Frame length: P*(1 + DATA_WIDTH + par_en + STOP_BITS) cycles, from edge k+1 to the return to IDLE.
- tx_ready=0 and busy=1 in every non-IDLE state.
- In IDLE, tx_out=1. A new accept is possible in the first IDLE cycle, so back-to-back frames are separated by exactly 1 idle-high clk.
- tx_valid while busy is ignored; the source must hold it until tx_ready.

Test Plan:
- Basic frame: rst then release; prescale=8, par_en=0, accept tx_data=0xA5.
  - tx_out is 0 for 8 cycles, then 1,0,1,0,0,1,0,1 (8 cycles each), then 1 for 8 cycles.
  - busy is high for 80 cycles; tx_ready returns to 1 on cycle 81.
- Parity types: prescale=4, par_en=1.
  - 0xA5 with par_typ=0 gives parity bit 0; with par_typ=1 it gives 1.
  - 0x07 with par_typ=0 gives parity bit 1.
  - Frame is 44 cycles each.
- Back-to-back: hold tx_valid=1 with 0x55 then 0x0F, prescale=2.
  - Second start bit begins exactly 1 idle-high cycle after the first stop bit ends.
  - Byte order is preserved.
- Mid-frame input change: accept 0x3C at prescale=8, then change prescale to 16 and tx_data to 0xFF during DATA.
  - Frame still matches 0x3C at 8 cycles/bit; tx_valid pulses while busy are ignored.
- Reset mid-frame: assert rst during data bit 3.
  - On the next edge tx_out=1, busy=0, tx_ready=1.
  - A fresh accept afterwards produces a clean full frame.
- Prescale edges:
  - prescale=1 with 0x81 gives a 10-cycle frame.
  - prescale=0 with 0x00 gives a start bit lasting 64 cycles and a total frame of 640 cycles.
